// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter for the UART TX FIFO enqueue port
//
// Shares one TX FIFO enqueue port among NUM_REQ byte-stream requesters.
// A winner keeps the port until its last byte, a MAX_BURST byte limit, or
// HOLD_TIMEOUT cycles of holding req_valid low.
//
// Ports:
//   clock, reset         - single clock, asynchronous active-low reset
//   enable               - gates issuing of new grants (a grant in progress completes)
//   req_valid/req_data/req_last/req_ready - per-requester byte streams (8 bits each)
//   tx_enq_valid/tx_enq_bits/tx_enq_ready - TX FIFO enqueue port
//   grant                - one-hot current owner, zero when idle
//   busy                 - high while a grant is held (SEND)
//   burst_cut            - one-cycle pulse after a forced release at MAX_BURST
//   hold_timeout         - one-cycle pulse after a stall-timeout release
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_enq_valid,
    output logic [7:0]             tx_enq_bits,
    input  logic                   tx_enq_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   burst_cut,
    output logic                   hold_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST);
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [IW-1:0]      PTR_INIT   = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0]      BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0]      TO_LAST    = TW'(HOLD_TIMEOUT - 1);
    localparam logic [TW-1:0]      TO_MAX     = TW'(HOLD_TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_ptr;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] to_cnt;

    // Owner's stream, selected through the one-hot grant; all zero in IDLE
    // because grant is zero there.
    logic own_valid;
    logic own_last;

    always_comb begin
        own_valid   = 1'b0;
        own_last    = 1'b0;
        tx_enq_bits = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_valid   = req_valid[i];
                own_last    = req_last[i];
                tx_enq_bits = req_data[8*i +: 8];
            end
        end
    end

    assign tx_enq_valid = own_valid;
    assign req_ready    = grant & {NUM_REQ{tx_enq_ready}};
    assign busy         = (state == SEND);

    // Round-robin pick: first valid requester starting just above last_ptr.
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [IW-1:0] cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_ptr) + k) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Release decisions for the current SEND cycle. A last byte takes
    // priority over the burst limit so a packet that ends exactly at the
    // limit is a normal release.
    logic handshake;
    logic rel_last;
    logic rel_burst;
    logic rel_timeout;

    always_comb begin
        handshake   = busy && own_valid && tx_enq_ready;
        rel_last    = handshake && own_last;
        rel_burst   = handshake && !own_last && (byte_cnt == BURST_LAST);
        rel_timeout = busy && !own_valid && (to_cnt == TO_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            last_ptr     <= PTR_INIT;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            burst_cut    <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            burst_cut    <= 1'b0;
            hold_timeout <= 1'b0;
            if (state == IDLE) begin
                if (enable && arb_found) begin
                    state    <= SEND;
                    owner    <= arb_idx;
                    grant    <= ONE_HOT0 << arb_idx;
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                end
            end else begin
                if (handshake) begin
                    byte_cnt <= byte_cnt + BW'(1);
                    to_cnt   <= '0;
                end else if (!own_valid && to_cnt != TO_MAX) begin
                    // Backpressure (valid high, ready low) leaves to_cnt alone.
                    to_cnt <= to_cnt + TW'(1);
                end
                if (rel_last || rel_burst || rel_timeout) begin
                    state        <= IDLE;
                    grant        <= '0;
                    last_ptr     <= owner;
                    burst_cut    <= rel_burst;
                    hold_timeout <= rel_timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_enq_valid;
    logic [7:0]  tx_enq_bits;
    logic        tx_enq_ready;
    logic [2:0]  grant;
    logic        busy;
    logic        burst_cut;
    logic        hold_timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-requester byte scripts: {last, byte}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    // Bytes seen entering the FIFO
    logic [7:0] log_b[$];
    int         log_c[$];
    logic [2:0] log_g[$];

    uart_tx_arbiter #(
        .NUM_REQ(3),
        .MAX_BURST(16),
        .HOLD_TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_enq_valid(tx_enq_valid),
        .tx_enq_bits(tx_enq_bits),
        .tx_enq_ready(tx_enq_ready),
        .grant(grant),
        .busy(busy),
        .burst_cut(burst_cut),
        .hold_timeout(hold_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        req_data  = '0;
        req_last  = '0;
        if (q0.size() != 0) begin req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8]; end
        if (q1.size() != 0) begin req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8]; end
        if (q2.size() != 0) begin req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8]; end
    endtask

    task automatic step();
        logic [2:0] acc;
        acc = req_valid & req_ready;
        if (tx_enq_valid && tx_enq_ready) begin
            log_b.push_back(tx_enq_bits);
            log_c.push_back(cyc);
            log_g.push_back(grant);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
        drive();
        #1;
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
        log_g.delete();
        cyc = 0;
    endtask

    task automatic chk_log(input string tag, input int k, input logic [7:0] b, input int c, input logic [2:0] g);
        chk($sformatf("%s[%0d].byte", tag, k), (k < log_b.size()) ? 32'(log_b[k]) : 32'hFFFF_FFFF, 32'(b));
        chk($sformatf("%s[%0d].cycle", tag, k), (k < log_c.size()) ? 32'(log_c[k]) : 32'hFFFF_FFFF, 32'(c));
        chk($sformatf("%s[%0d].grant", tag, k), (k < log_g.size()) ? 32'(log_g[k]) : 32'hFFFF_FFFF, 32'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eb;
        int pkt;

        tx_enq_ready = 1'b1;
        drive();
        #12;
        // Reset state
        chk("rst.req_ready", 32'(req_ready), 32'h0);
        chk("rst.tx_enq_valid", 32'(tx_enq_valid), 32'h0);
        chk("rst.tx_enq_bits", 32'(tx_enq_bits), 32'h0);
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.burst_cut", 32'(burst_cut), 32'h0);
        chk("rst.hold_timeout", 32'(hold_timeout), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;

        // Fairness: three requesters, two 2-byte packets each
        for (int r = 0; r < 2; r++) begin
            q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h20});
            q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h21});
            q2.push_back({1'b0, 8'h12}); q2.push_back({1'b1, 8'h22});
        end
        drive();
        #1;
        clear_log();
        chk("fair.grant_t0", 32'(grant), 32'h0);
        for (int n = 0; n < 40 && log_b.size() < 12; n++) step();
        chk("fair.count", 32'(log_b.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            pkt = k / 2;
            eb = ((k % 2) != 0) ? 8'h20 : 8'h10;
            eb = eb + 8'(pkt % 3);
            chk_log("fair", k, eb, 1 + 3 * pkt + (k % 2), 3'b001 << (pkt % 3));
        end
        chk("fair.end_busy", 32'(busy), 32'h0);
        chk("fair.end_grant", 32'(grant), 32'h0);

        // Single packet from requester 1
        q1.push_back({1'b0, 8'h33});
        q1.push_back({1'b1, 8'hCC});
        drive();
        #1;
        clear_log();
        chk("single.grant_t0", 32'(grant), 32'h0);
        step();
        chk("single.grant_t1", 32'(grant), 32'b010);
        chk("single.req_ready", 32'(req_ready), 32'b010);
        chk("single.tx_valid", 32'(tx_enq_valid), 32'h1);
        chk("single.bits0", 32'(tx_enq_bits), 32'h33);
        chk("single.busy", 32'(busy), 32'h1);
        step();
        chk("single.bits1", 32'(tx_enq_bits), 32'hCC);
        step();
        chk("single.busy_after", 32'(busy), 32'h0);
        chk("single.grant_after", 32'(grant), 32'h0);
        chk_log("single", 0, 8'h33, 1, 3'b010);
        chk_log("single", 1, 8'hCC, 2, 3'b010);

        // Burst cut: req0 streams 20 bytes without last, req2 waits
        for (int k = 0; k < 20; k++) q0.push_back({1'b0, 8'(k)});
        drive();
        #1;
        clear_log();
        step();
        q2.push_back({1'b0, 8'h77});
        q2.push_back({1'b1, 8'h78});
        drive();
        #1;
        while (cyc < 92) begin
            if (cyc == 16 || cyc == 18) chk($sformatf("burst.cut_c%0d", cyc), 32'(burst_cut), 32'h0);
            if (cyc == 17) begin
                chk("burst.cut_c17", 32'(burst_cut), 32'h1);
                chk("burst.grant_c17", 32'(grant), 32'h0);
            end
            if (cyc == 18) chk("burst.grant_c18", 32'(grant), 32'b100);
            if (cyc == 88) chk("burst.to_c88", 32'(hold_timeout), 32'h0);
            if (cyc == 89) chk("burst.to_c89", 32'(hold_timeout), 32'h1);
            step();
        end
        chk("burst.count", 32'(log_b.size()), 32'd22);
        for (int k = 0; k < 16; k++) chk_log("burst", k, 8'(k), 1 + k, 3'b001);
        chk_log("burst", 16, 8'h77, 18, 3'b100);
        chk_log("burst", 17, 8'h78, 19, 3'b100);
        for (int k = 18; k < 22; k++) chk_log("burst", k, 8'h10 + 8'(k - 18), 21 + (k - 18), 3'b001);

        // Timeout: req1 sends one byte then stalls; req2 pending
        q1.push_back({1'b0, 8'h55});
        q2.push_back({1'b1, 8'h99});
        drive();
        #1;
        clear_log();
        while (cyc < 70) begin
            if (cyc == 65) begin
                chk("to.pulse_c65", 32'(hold_timeout), 32'h0);
                chk("to.grant_c65", 32'(grant), 32'b010);
            end
            if (cyc == 66) begin
                chk("to.pulse_c66", 32'(hold_timeout), 32'h1);
                chk("to.grant_c66", 32'(grant), 32'h0);
                chk("to.busy_c66", 32'(busy), 32'h0);
            end
            if (cyc == 67) begin
                chk("to.pulse_c67", 32'(hold_timeout), 32'h0);
                chk("to.grant_c67", 32'(grant), 32'b100);
                chk("to.bits_c67", 32'(tx_enq_bits), 32'h99);
            end
            step();
        end
        chk("to.count", 32'(log_b.size()), 32'd2);
        chk_log("to", 0, 8'h55, 1, 3'b010);
        chk_log("to", 1, 8'h99, 67, 3'b100);

        // Backpressure: ready low for 200 cycles during req0's packet
        tx_enq_ready = 1'b0;
        q0.push_back({1'b0, 8'hAA});
        q0.push_back({1'b1, 8'h55});
        drive();
        #1;
        clear_log();
        while (cyc < 201) begin
            if (cyc == 100 || cyc == 200) begin
                chk($sformatf("bp.req_ready_c%0d", cyc), 32'(req_ready), 32'h0);
                chk($sformatf("bp.tx_valid_c%0d", cyc), 32'(tx_enq_valid), 32'h1);
                chk($sformatf("bp.bits_c%0d", cyc), 32'(tx_enq_bits), 32'hAA);
                chk($sformatf("bp.grant_c%0d", cyc), 32'(grant), 32'b001);
                chk($sformatf("bp.to_c%0d", cyc), 32'(hold_timeout), 32'h0);
            end
            if (cyc == 200) chk("bp.none_accepted", 32'(log_b.size()), 32'd0);
            step();
        end
        tx_enq_ready = 1'b1;
        #1;
        chk("bp.req_ready_back", 32'(req_ready), 32'b001);
        step();
        step();
        chk("bp.busy_end", 32'(busy), 32'h0);
        chk_log("bp", 0, 8'hAA, 201, 3'b001);
        chk_log("bp", 1, 8'h55, 202, 3'b001);

        // Reset mid-packet, then enable gating
        q1.push_back({1'b0, 8'h01});
        q1.push_back({1'b0, 8'h02});
        q1.push_back({1'b1, 8'h03});
        drive();
        #1;
        step();
        step();
        chk("rm.grant_before", 32'(grant), 32'b010);
        reset = 1'b0;
        #1;
        chk("rm.grant", 32'(grant), 32'h0);
        chk("rm.busy", 32'(busy), 32'h0);
        chk("rm.req_ready", 32'(req_ready), 32'h0);
        chk("rm.tx_valid", 32'(tx_enq_valid), 32'h0);
        chk("rm.tx_bits", 32'(tx_enq_bits), 32'h0);
        q1.delete();
        drive();
        step();
        step();
        enable = 1'b0;
        reset = 1'b1;
        q0.push_back({1'b1, 8'h44});
        q1.push_back({1'b1, 8'h45});
        drive();
        #1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("en.grant_off%0d", n), 32'(grant), 32'h0);
        end
        enable = 1'b1;
        #1;
        chk("en.grant_pre", 32'(grant), 32'h0);
        step();
        chk("en.grant_req0", 32'(grant), 32'b001);
        chk("en.bits_req0", 32'(tx_enq_bits), 32'h44);
        step();
        chk("en.bubble", 32'(grant), 32'h0);
        step();
        chk("en.grant_req1", 32'(grant), 32'b010);
        chk("en.bits_req1", 32'(tx_enq_bits), 32'h45);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
